// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM states, default geometry and width helpers for the stage-2 window sequencer
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LTAIL,
        ST_MSTART,
        ST_MWAIT,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } conv_state_e;

    localparam int DEF_IFM_W   = 13;
    localparam int DEF_K       = 4;
    localparam int DEF_STRIDE  = 2;
    localparam int DEF_TIMEOUT = 64;

    function automatic int out_w(input int ifm_w, input int k, input int stride);
        return (ifm_w - k) / stride + 1;
    endfunction

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2_addr_gen.sv
// rtl/conv2_addr_gen.sv - buffer read address of window slot idx for output position (row, col)
module conv2_addr_gen
    import conv_pkg::*;
#(
    parameter int IFM_W  = DEF_IFM_W,
    parameter int K      = DEF_K,
    parameter int STRIDE = DEF_STRIDE,
    parameter int RC_W   = 3,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 8
) (
    input  logic [RC_W-1:0]   row_i,
    input  logic [RC_W-1:0]   col_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] idx_x;
    logic [ADDR_W-1:0] pix_row;
    logic [ADDR_W-1:0] pix_col;

    // ADDR_W covers IFM_W*IFM_W-1, so every intermediate stays below that bound.
    always_comb begin
        idx_x   = ADDR_W'(idx_i);
        pix_row = ADDR_W'(row_i) * ADDR_W'(STRIDE) + idx_x / ADDR_W'(K);
        pix_col = ADDR_W'(col_i) * ADDR_W'(STRIDE) + idx_x % ADDR_W'(K);
        addr_o  = pix_row * ADDR_W'(IFM_W) + pix_col;
    end

endmodule

// File: rtl/conv2_window_sequencer.sv
// rtl/conv2_window_sequencer.sv - stage-2 conv window walker: load window, run PE2 MAC, write OFM word
// Optional MAC watchdog enabled by CONV2_MAC_TIMEOUT_EN.
module conv2_window_sequencer
    import conv_pkg::*;
#(
    parameter  int IFM_W   = DEF_IFM_W,
    parameter  int K       = DEF_K,
    parameter  int STRIDE  = DEF_STRIDE,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int OUT_W   = out_w(IFM_W, K, STRIDE),
    localparam int ADDR_W  = cw(IFM_W * IFM_W),
    localparam int OFM_AW  = cw(OUT_W * OUT_W),
    localparam int IDX_W   = cw(K * K)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              buf_rd_en_o,
    output logic [ADDR_W-1:0] buf_rd_addr_o,
    output logic              win_we_o,
    output logic [IDX_W-1:0]  win_idx_o,
    output logic              mac_start_o,
    input  logic              mac_done_i,
    output logic              ofm_wr_o,
    input  logic              ofm_ready_i,
    output logic [OFM_AW-1:0] ofm_addr_o,
    output logic              err_o
);

    localparam int RC_W = cw(OUT_W);

    conv_state_e       state_q, state_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [RC_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OFM_AW-1:0] ofm_addr_q, ofm_addr_d;
    logic              win_we_q;
    logic [IDX_W-1:0]  win_idx_q;
    logic              tmo_hit;

    logic last_idx, last_col, last_row;
    assign last_idx = (idx_q == IDX_W'(K * K - 1));
    assign last_col = (col_q == RC_W'(OUT_W - 1));
    assign last_row = (row_q == RC_W'(OUT_W - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            idx_q      <= '0;
            ofm_addr_q <= '0;
            win_we_q   <= 1'b0;
            win_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            idx_q      <= idx_d;
            ofm_addr_q <= ofm_addr_d;
            // Buffer data lands one cycle after the read, so the slot write trails it.
            win_we_q   <= (state_q == ST_LOAD);
            win_idx_q  <= idx_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        idx_d      = idx_q;
        ofm_addr_d = ofm_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_LOAD;
                    row_d      = '0;
                    col_d      = '0;
                    idx_d      = '0;
                    ofm_addr_d = '0;
                end
            end
            ST_LOAD: begin
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = ST_LTAIL;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_LTAIL:  state_d = ST_MSTART;
            ST_MSTART: state_d = ST_MWAIT;
            ST_MWAIT: begin
                if (mac_done_i) begin
                    state_d = ST_WRITE;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (ofm_ready_i) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_row && last_col) begin
                    state_d = ST_DONE;
                end else begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    ofm_addr_d = ofm_addr_q + 1'b1;
                    idx_d      = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef CONV2_MAC_TIMEOUT_EN
    localparam int TMO_W = cw(TIMEOUT);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit = (state_q == ST_MWAIT) && !mac_done_i && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == ST_MWAIT) ? tmo_q + 1'b1 : '0;
            if (state_q == ST_IDLE && start_i) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    conv2_addr_gen #(
        .IFM_W (IFM_W),
        .K     (K),
        .STRIDE(STRIDE),
        .RC_W  (RC_W),
        .IDX_W (IDX_W),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .row_i (row_q),
        .col_i (col_q),
        .idx_i (idx_q),
        .addr_o(buf_rd_addr_o)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign buf_rd_en_o = (state_q == ST_LOAD);
    assign mac_start_o = (state_q == ST_MSTART);
    assign ofm_wr_o    = (state_q == ST_WRITE);
    assign ofm_addr_o  = ofm_addr_q;
    assign win_we_o    = win_we_q;
    assign win_idx_o   = win_idx_q;

endmodule
